// File: rtl/id_ex_hazard_stage.sv
// ============================================================================
// Module   : id_ex_hazard_stage
// Purpose  : ID/EX pipeline register with control decode, load-use hazard
//            detection and taken-branch flush. Optional stall counter is
//            enabled with `define ID_EX_STALL_CNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module id_ex_hazard_stage #(
  parameter int CNT_W = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        PCSrc,
  input  logic [31:0] PC_ID,
  input  logic [31:0] IMM_ID,
  input  logic [31:0] REG_DATA1_ID,
  input  logic [31:0] REG_DATA2_ID,
  input  logic [2:0]  FUNCT3_ID,
  input  logic [6:0]  FUNCT7_ID,
  input  logic [6:0]  OPCODE_ID,
  input  logic [4:0]  RD_ID,
  input  logic [4:0]  RS1_ID,
  input  logic [4:0]  RS2_ID,
  output logic        PC_write,
  output logic        IF_ID_write,
  output logic [31:0] PC_EX,
  output logic [31:0] IMM_EX,
  output logic [31:0] REG_DATA1_EX,
  output logic [31:0] REG_DATA2_EX,
  output logic [2:0]  FUNCT3_EX,
  output logic [6:0]  FUNCT7_EX,
  output logic [4:0]  RD_EX,
  output logic [4:0]  RS1_EX,
  output logic [4:0]  RS2_EX,
  output logic        RegWrite_EX,
  output logic        MemtoReg_EX,
  output logic        MemRead_EX,
  output logic        MemWrite_EX,
  output logic        Branch_EX,
  output logic        ALUSrc_EX,
  output logic [1:0]  ALUOp_EX,
  output logic        VALID_EX
`ifdef ID_EX_STALL_CNT_EN
  ,
  output logic [CNT_W-1:0] STALL_CNT
`endif
);

  localparam logic [6:0] c_op_r      = 7'b0110011;
  localparam logic [6:0] c_op_i      = 7'b0010011;
  localparam logic [6:0] c_op_load   = 7'b0000011;
  localparam logic [6:0] c_op_store  = 7'b0100011;
  localparam logic [6:0] c_op_branch = 7'b1100011;

  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_STALL = 1'b1
  } state_t;

  state_t     r_state;
  logic [7:0] w_ctrl;     // {RegWrite,MemtoReg,MemRead,MemWrite,Branch,ALUSrc,ALUOp}
  logic       w_known;
  logic       w_rs1_used;
  logic       w_rs2_used;
  logic       w_stall;
  logic       w_bubble;

  always_comb begin
    w_ctrl     = 8'b0000_0000;
    w_known    = 1'b0;
    w_rs1_used = 1'b0;
    w_rs2_used = 1'b0;
    case (OPCODE_ID)
      c_op_r: begin
        w_ctrl = 8'b1000_0010; w_known = 1'b1; w_rs1_used = 1'b1; w_rs2_used = 1'b1;
      end
      c_op_i: begin
        w_ctrl = 8'b1000_0111; w_known = 1'b1; w_rs1_used = 1'b1;
      end
      c_op_load: begin
        w_ctrl = 8'b1110_0100; w_known = 1'b1; w_rs1_used = 1'b1;
      end
      c_op_store: begin
        w_ctrl = 8'b0001_0100; w_known = 1'b1; w_rs1_used = 1'b1; w_rs2_used = 1'b1;
      end
      c_op_branch: begin
        w_ctrl = 8'b0000_1001; w_known = 1'b1; w_rs1_used = 1'b1; w_rs2_used = 1'b1;
      end
      default: begin
        w_ctrl  = 8'b0000_0000;
        w_known = 1'b0;
      end
    endcase
  end

  assign w_stall = VALID_EX && MemRead_EX && (RD_EX != 5'd0) &&
                   (((RD_EX == RS1_ID) && w_rs1_used) || ((RD_EX == RS2_ID) && w_rs2_used));

  // A taken branch overrides the hazard: the held instruction is discarded anyway.
  assign PC_write    = !reset || PCSrc || !w_stall;
  assign IF_ID_write = !reset || PCSrc || !w_stall;
  assign w_bubble    = PCSrc || w_stall;

  always_ff @(posedge clk) begin
    if (!reset || w_bubble) begin
      PC_EX        <= 32'd0;
      IMM_EX       <= 32'd0;
      REG_DATA1_EX <= 32'd0;
      REG_DATA2_EX <= 32'd0;
      FUNCT3_EX    <= 3'd0;
      FUNCT7_EX    <= 7'd0;
      RD_EX        <= 5'd0;
      RS1_EX       <= 5'd0;
      RS2_EX       <= 5'd0;
      RegWrite_EX  <= 1'b0;
      MemtoReg_EX  <= 1'b0;
      MemRead_EX   <= 1'b0;
      MemWrite_EX  <= 1'b0;
      Branch_EX    <= 1'b0;
      ALUSrc_EX    <= 1'b0;
      ALUOp_EX     <= 2'b00;
      VALID_EX     <= 1'b0;
    end else begin
      PC_EX        <= PC_ID;
      IMM_EX       <= IMM_ID;
      REG_DATA1_EX <= REG_DATA1_ID;
      REG_DATA2_EX <= REG_DATA2_ID;
      FUNCT3_EX    <= FUNCT3_ID;
      FUNCT7_EX    <= FUNCT7_ID;
      RD_EX        <= RD_ID;
      RS1_EX       <= RS1_ID;
      RS2_EX       <= RS2_ID;
      RegWrite_EX  <= w_ctrl[7];
      MemtoReg_EX  <= w_ctrl[6];
      MemRead_EX   <= w_ctrl[5];
      MemWrite_EX  <= w_ctrl[4];
      Branch_EX    <= w_ctrl[3];
      ALUSrc_EX    <= w_ctrl[2];
      ALUOp_EX     <= w_ctrl[1:0];
      VALID_EX     <= w_known;
    end
  end

  // The stall bubble clears MemRead_EX, so STALL always falls back to RUN.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= ST_RUN;
    end else begin
      case (r_state)
        ST_RUN:   r_state <= (w_stall && !PCSrc) ? ST_STALL : ST_RUN;
        ST_STALL: r_state <= ST_RUN;
        default:  r_state <= ST_RUN;
      endcase
    end
  end

`ifdef ID_EX_STALL_CNT_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      STALL_CNT <= '0;
    end else if (w_stall && !PCSrc && (STALL_CNT != {CNT_W{1'b1}})) begin
      STALL_CNT <= STALL_CNT + 1'b1;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_id_ex_hazard_stage.sv
// ============================================================================
// Module   : tb_id_ex_hazard_stage
// Purpose  : Scoreboard bench for id_ex_hazard_stage (counter checks active
//            when ID_EX_STALL_CNT_EN is defined).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_id_ex_hazard_stage;

  localparam int c_cnt_w = 4;

  localparam logic [6:0] c_r  = 7'b0110011;
  localparam logic [6:0] c_i  = 7'b0010011;
  localparam logic [6:0] c_ld = 7'b0000011;
  localparam logic [6:0] c_st = 7'b0100011;
  localparam logic [6:0] c_br = 7'b1100011;
  localparam logic [6:0] c_xx = 7'b1111111;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        PCSrc = 1'b0;
  logic [31:0] PC_ID = '0, IMM_ID = '0, REG_DATA1_ID = '0, REG_DATA2_ID = '0;
  logic [2:0]  FUNCT3_ID = '0;
  logic [6:0]  FUNCT7_ID = '0, OPCODE_ID = '0;
  logic [4:0]  RD_ID = '0, RS1_ID = '0, RS2_ID = '0;
  logic        PC_write, IF_ID_write;
  logic [31:0] PC_EX, IMM_EX, REG_DATA1_EX, REG_DATA2_EX;
  logic [2:0]  FUNCT3_EX;
  logic [6:0]  FUNCT7_EX;
  logic [4:0]  RD_EX, RS1_EX, RS2_EX;
  logic        RegWrite_EX, MemtoReg_EX, MemRead_EX, MemWrite_EX, Branch_EX, ALUSrc_EX;
  logic [1:0]  ALUOp_EX;
  logic        VALID_EX;
`ifdef ID_EX_STALL_CNT_EN
  logic [c_cnt_w-1:0] STALL_CNT;
`endif

  id_ex_hazard_stage #(.CNT_W(c_cnt_w)) u_dut (
    .clk(clk), .reset(reset), .PCSrc(PCSrc),
    .PC_ID(PC_ID), .IMM_ID(IMM_ID), .REG_DATA1_ID(REG_DATA1_ID), .REG_DATA2_ID(REG_DATA2_ID),
    .FUNCT3_ID(FUNCT3_ID), .FUNCT7_ID(FUNCT7_ID), .OPCODE_ID(OPCODE_ID),
    .RD_ID(RD_ID), .RS1_ID(RS1_ID), .RS2_ID(RS2_ID),
    .PC_write(PC_write), .IF_ID_write(IF_ID_write),
    .PC_EX(PC_EX), .IMM_EX(IMM_EX), .REG_DATA1_EX(REG_DATA1_EX), .REG_DATA2_EX(REG_DATA2_EX),
    .FUNCT3_EX(FUNCT3_EX), .FUNCT7_EX(FUNCT7_EX),
    .RD_EX(RD_EX), .RS1_EX(RS1_EX), .RS2_EX(RS2_EX),
    .RegWrite_EX(RegWrite_EX), .MemtoReg_EX(MemtoReg_EX), .MemRead_EX(MemRead_EX),
    .MemWrite_EX(MemWrite_EX), .Branch_EX(Branch_EX), .ALUSrc_EX(ALUSrc_EX),
    .ALUOp_EX(ALUOp_EX), .VALID_EX(VALID_EX)
`ifdef ID_EX_STALL_CNT_EN
    , .STALL_CNT(STALL_CNT)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  ctrl;
    logic        valid;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] pc, imm, d1, d2;
  } ex_t;

  ex_t     r_exp_q[$];
  ex_t     r_model;
  int      r_checks = 0;
  int      r_errors = 0;
  int      r_cnt_model = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    r_checks++;
    if (obs !== exp) begin
      r_errors++;
      $display("FAIL %s: observed=0x%0h expected=0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference control table: {RegWrite,MemtoReg,MemRead,MemWrite,Branch,ALUSrc,ALUOp}
  function automatic void ref_decode(input logic [6:0] op, output logic [7:0] ctrl,
                                     output logic known, output logic u1, output logic u2);
    ctrl = 8'h00; known = 1'b1; u1 = 1'b1; u2 = 1'b0;
    if      (op == c_r)  begin ctrl = {1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b10}; u2 = 1'b1; end
    else if (op == c_i)  ctrl = {1'b1,1'b0,1'b0,1'b0,1'b0,1'b1,2'b11};
    else if (op == c_ld) ctrl = {1'b1,1'b1,1'b1,1'b0,1'b0,1'b1,2'b00};
    else if (op == c_st) begin ctrl = {1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,2'b00}; u2 = 1'b1; end
    else if (op == c_br) begin ctrl = {1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,2'b01}; u2 = 1'b1; end
    else begin known = 1'b0; u1 = 1'b0; end
  endfunction

  task automatic step(input logic rst_n, input logic br, input logic [6:0] op,
                      input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic [31:0] pc);
    logic [7:0] ctrl;
    logic       known, u1, u2, hz, exp_pcw;
    ex_t        nxt, got;
    @(negedge clk);
    reset = rst_n; PCSrc = br; OPCODE_ID = op; RD_ID = rd; RS1_ID = rs1; RS2_ID = rs2;
    PC_ID = pc; IMM_ID = $urandom; REG_DATA1_ID = $urandom; REG_DATA2_ID = $urandom;
    FUNCT3_ID = 3'($urandom); FUNCT7_ID = 7'($urandom);
    #1;
    ref_decode(op, ctrl, known, u1, u2);
    hz = r_model.valid && r_model.ctrl[5] && (r_model.rd != 5'd0) &&
         ((r_model.rd == rs1 && u1) || (r_model.rd == rs2 && u2));
    exp_pcw = !rst_n || br || !hz;
    check_eq("PC_write", 64'(PC_write), 64'(exp_pcw));
    check_eq("IF_ID_write", 64'(IF_ID_write), 64'(exp_pcw));
    nxt = '{ctrl: 8'h00, valid: 1'b0, rd: 5'd0, rs1: 5'd0, rs2: 5'd0, f3: 3'd0, f7: 7'd0,
            pc: 32'd0, imm: 32'd0, d1: 32'd0, d2: 32'd0};
    if (rst_n && !br && !hz)
      nxt = '{ctrl: ctrl, valid: known, rd: rd, rs1: rs1, rs2: rs2, f3: FUNCT3_ID,
              f7: FUNCT7_ID, pc: pc, imm: IMM_ID, d1: REG_DATA1_ID, d2: REG_DATA2_ID};
    if (!rst_n) r_cnt_model = 0;
    else if (hz && !br && r_cnt_model < (1 << c_cnt_w) - 1) r_cnt_model++;
    r_exp_q.push_back(nxt);
    r_model = nxt;
    @(posedge clk);
    #1;
    if (r_exp_q.size() == 0) begin
      check_eq("scoreboard_empty", 64'd1, 64'd0);
    end else begin
      got = r_exp_q.pop_front();
      check_eq("ctrl", {56'd0, RegWrite_EX, MemtoReg_EX, MemRead_EX, MemWrite_EX, Branch_EX,
                        ALUSrc_EX, ALUOp_EX}, 64'(got.ctrl));
      check_eq("VALID_EX", 64'(VALID_EX), 64'(got.valid));
      check_eq("regs", {49'd0, RD_EX, RS1_EX, RS2_EX}, {49'd0, got.rd, got.rs1, got.rs2});
      check_eq("funct", {54'd0, FUNCT3_EX, FUNCT7_EX}, {54'd0, got.f3, got.f7});
      check_eq("pc_imm", {PC_EX, IMM_EX}, {got.pc, got.imm});
      check_eq("data", {REG_DATA1_EX, REG_DATA2_EX}, {got.d1, got.d2});
    end
`ifdef ID_EX_STALL_CNT_EN
    check_eq("STALL_CNT", 64'(STALL_CNT), 64'(r_cnt_model));
`endif
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    r_model = '{ctrl: 8'h00, valid: 1'b0, rd: 5'd0, rs1: 5'd0, rs2: 5'd0, f3: 3'd0, f7: 7'd0,
                pc: 32'd0, imm: 32'd0, d1: 32'd0, d2: 32'd0};
    // Reset with arbitrary decode contents
    step(1'b0, 1'b0, c_ld, 5'd7, 5'd3, 5'd4, 32'h1234);
    step(1'b0, 1'b1, c_r,  5'd9, 5'd7, 5'd7, 32'h5678);
    // R-type passthrough
    step(1'b1, 1'b0, c_r, 5'd5, 5'd1, 5'd2, 32'h10);
    // Load-use on rs2, then the held R-type enters
    step(1'b1, 1'b0, c_ld, 5'd7, 5'd1, 5'd0, 32'h14);
    step(1'b1, 1'b0, c_r,  5'd8, 5'd2, 5'd7, 32'h18);
    step(1'b1, 1'b0, c_r,  5'd8, 5'd2, 5'd7, 32'h18);
    // Load to x0 followed by x0 user
    step(1'b1, 1'b0, c_ld, 5'd0, 5'd1, 5'd0, 32'h1c);
    step(1'b1, 1'b0, c_r,  5'd4, 5'd0, 5'd0, 32'h20);
    // rs2 field of I-arith is unused
    step(1'b1, 1'b0, c_ld, 5'd3, 5'd1, 5'd0, 32'h24);
    step(1'b1, 1'b0, c_i,  5'd4, 5'd5, 5'd3, 32'h28);
    // rs1 hazard on I-arith, rs2 hazard on store
    step(1'b1, 1'b0, c_ld, 5'd3, 5'd1, 5'd0, 32'h2c);
    step(1'b1, 1'b0, c_i,  5'd4, 5'd3, 5'd0, 32'h30);
    step(1'b1, 1'b0, c_i,  5'd4, 5'd3, 5'd0, 32'h30);
    step(1'b1, 1'b0, c_ld, 5'd6, 5'd1, 5'd0, 32'h34);
    step(1'b1, 1'b0, c_st, 5'd0, 5'd2, 5'd6, 32'h38);
    step(1'b1, 1'b0, c_st, 5'd0, 5'd2, 5'd6, 32'h38);
    // Flush beats a simultaneous hazard
    step(1'b1, 1'b0, c_ld, 5'd8, 5'd1, 5'd0, 32'h3c);
    step(1'b1, 1'b1, c_br, 5'd0, 5'd8, 5'd2, 32'h40);
    // Unknown opcode yields an invalid slot
    step(1'b1, 1'b0, c_xx, 5'd11, 5'd1, 5'd2, 32'h44);
    // Reset asserted during a hazard, then re-presented without one
    step(1'b1, 1'b0, c_ld, 5'd9, 5'd1, 5'd0, 32'h48);
    step(1'b0, 1'b0, c_r,  5'd2, 5'd9, 5'd1, 32'h4c);
    step(1'b1, 1'b0, c_r,  5'd2, 5'd9, 5'd1, 32'h4c);
    // 17 stall events drive the 4-bit counter into saturation
    for (int i = 0; i < 17; i++) begin
      step(1'b1, 1'b0, c_ld, 5'd12, 5'd1, 5'd0, 32'h100 + 32'(i * 8));
      step(1'b1, 1'b0, c_r,  5'd13, 5'd12, 5'd2, 32'h104 + 32'(i * 8));
      step(1'b1, 1'b0, c_r,  5'd13, 5'd12, 5'd2, 32'h104 + 32'(i * 8));
    end
    // Random traffic with small register indices to provoke hazards
    for (int i = 0; i < 60; i++) begin
      logic [6:0] op;
      case ($urandom_range(0, 5))
        0: op = c_r; 1: op = c_i; 2: op = c_ld; 3: op = c_st; 4: op = c_br; default: op = c_xx;
      endcase
      step(($urandom_range(0, 19) != 0), ($urandom_range(0, 7) == 0), op,
           5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
           $urandom);
    end
    $display("Result: errors=%0d of %0d checks", r_errors, r_checks);
    $finish;
  end

endmodule

`default_nettype wire
